proc_core_lite: RTL
===================

Name: proc_core_lite

Overview:
- Minimal 16-bit two-stage processor core. It is the device-side counterpart of the processor bench interface.
- It consumes the instruction word driven on inst_in each cycle and presents the fetch PC.
- It reports every retired instruction on inst_out, together with that instruction's register-file write (reg_*) and data-memory write (mem_*), for the monitor to sample.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- JMP_SQUASH, 1, when 1 the instruction captured behind a JMP retires as a bubble.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- inst_in  input  16  instruction word for the current pc; captured on posedge.
- pc  output  8  fetch address for the next instruction the environment supplies.
- inst_out  output  16  instruction retired at the last posedge (16'h0000 for a bubble).
- reg_data  output  16  value written to the register file by the retired instruction.
- reg_en  output  2  00 no write, 01 ALU/MOVI write, 10 load write, 11 never driven.
- reg_add  output  3  destination register index.
- mem_data  output  16  value stored to data memory.
- mem_en  output  1  1 when the retired instruction was a store.
- mem_add  output  3  data-memory address of the store.

Behaviour:
- Encoding: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0], addr=[2:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2.
  - 2 SUB rd=rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MOVI rd={8'h00,imm8}.
  - 7 LD rd=DM[addr].
  - 8 ST DM[addr]=R[rs1].
  - 9 JMP pc=imm8.
  - 10-15 behave as NOP.
- All arithmetic is 16-bit modulo 2^16; no flags.
- State: R[0..7] x16 and DM[0..7] x16, all cleared to 0 on reset. R0 is an ordinary writable register.
- Stage D (posedge N): inst_in is latched into IR and v_d is set to 1. pc <= pc+1, wrapping 8'hFF -> 8'h00.
- Stage X/retire (posedge N+1): when v_d=1, IR executes. Operands are read combinationally from the current R/DM. R/DM are updated at this same edge, and all retire outputs are registered at this same edge. Retire latency is therefore 2 posedges after inst_in is presented.
- Back-to-back dependencies need no forwarding, because each instruction reads its operands one cycle after the previous write has landed.
- Retire outputs:
  - inst_out=IR.
  - ALU op or MOVI: reg_en=01, reg_add=rd, reg_data=result.
  - LD: reg_en=10, reg_add=rd, reg_data=DM[addr].
  - ST: mem_en=1, mem_add=addr, mem_data=R[rs1].
- Any output not asserted by the retiring instruction returns to 0 at that edge; outputs are single-cycle pulses, not held.
- NOP, undefined opcodes and JMP: reg_en=00, mem_en=0, data/address outputs 0, inst_out=IR.
- JMP: at its retire edge pc <= imm8, taking priority over the increment.
  - With JMP_SQUASH=1, the instruction latched at that same edge is marked invalid: it retires next cycle with inst_out=16'h0000 and all enables 0.
  - JMP to the current pc value is legal.
- Reset values (applied asynchronously on rst=1):
  - pc=PC_RESET.
  - inst_out, reg_data, reg_add, mem_data, mem_add = 0.
  - reg_en=00, mem_en=0.
  - v_d=0, IR=0.
- Reset mid-operation discards the in-flight instruction; no partial write occurs.
- First cycle after reset release: inst_in is captured and retire outputs stay 0 (v_d=0 bubble). The first real retire occurs at the second posedge.
- Outputs change only on posedge. The environment drives on negedge and samples on negedge, so every value is stable for the full sampling window.

Test Plan:
- Reset, then MOVI R1,0x05 (16'h6205) and MOVI R2,0x03 (16'h6403) -> retire on posedges 2 and 3 with reg_en=01, reg_add=1/2, reg_data=0x0005/0x0003; pc counts 0,1,2,3.
- Continue with ADD R3,R1,R2 (16'h1650) immediately after the MOVIs -> reg_add=3, reg_data=0x0008, with no stall and no forwarding error.
- ST DM[4]=R3 (16'h80C4) then LD R5,DM[4] (16'h7A04) -> first retire: mem_en=1, mem_add=4, mem_data=0x0008, reg_en=00; second retire: reg_en=10, reg_add=5, reg_data=0x0008.
- JMP 0x40 (16'h9040) followed by ADD -> pc=0x40 after the JMP retire edge; the following slot retires inst_out=0, reg_en=00; the instruction fetched at 0x40 retires normally.
- MOVI R1,0x00 then SUB R2,R1,R1+1 (R1=0, R0=1 prepared): 0-1 -> reg_data=0xFFFF. Run pc from 0xFE through 3 instructions -> pc sequence 0xFF, 0x00, 0x01.
- Assert rst asynchronously between edges while an ST is in stage D -> outputs clear immediately, DM unchanged (all 0), pc=PC_RESET, and no mem_en pulse after release.

Source files
------------

// File: rtl/proc_core_lite_if.sv
// Fetch/retire bus between the two-stage core and its environment.
// The environment drives inst_in; the core drives pc and all retire reporting.
interface proc_core_lite_if;
   logic [15:0] inst_in;
   logic [7:0]  pc;
   logic [15:0] inst_out;
   logic [15:0] reg_data;
   logic [1:0]  reg_en;
   logic [2:0]  reg_add;
   logic [15:0] mem_data;
   logic        mem_en;
   logic [2:0]  mem_add;

   modport master (
      output inst_in,
      input  pc, inst_out, reg_data, reg_en, reg_add, mem_data, mem_en, mem_add
   );

   modport slave (
      input  inst_in,
      output pc, inst_out, reg_data, reg_en, reg_add, mem_data, mem_en, mem_add
   );
endinterface

// File: rtl/proc_core_lite.sv
// Minimal 16-bit two-stage core: capture into IR at one edge, execute and retire at the next.
// Retire reporting is registered and pulses for one cycle per retired instruction.
module proc_core_lite #(
   parameter logic [7:0] PC_RESET   = 8'h00,
   parameter bit         JMP_SQUASH = 1'b1
) (
   input logic              clk,
   input logic              rst,
   proc_core_lite_if.slave  bus
);
   logic [15:0] ir;
   logic        v_d;
   logic [7:0]  pc_q;
   logic [15:0] rf [0:7];
   logic [15:0] dm [0:7];

   logic [3:0]  op;
   logic [2:0]  rd, rs1, rs2, addr;
   logic [7:0]  imm8;
   logic [15:0] opa, opb, alu;
   logic        is_jmp;

   assign op   = ir[15:12];
   assign rd   = ir[11:9];
   assign rs1  = ir[8:6];
   assign rs2  = ir[5:3];
   assign imm8 = ir[7:0];
   assign addr = ir[2:0];
   assign opa  = rf[rs1];
   assign opb  = rf[rs2];
   assign is_jmp = v_d && (op == 4'd9);
   assign bus.pc = pc_q;

   always_comb begin
      alu = 16'h0000;
      case (op)
         4'd1:    alu = opa + opb;
         4'd2:    alu = opa - opb;
         4'd3:    alu = opa & opb;
         4'd4:    alu = opa | opb;
         4'd5:    alu = opa ^ opb;
         4'd6:    alu = {8'h00, imm8};
         default: alu = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir           <= 16'h0000;
         v_d          <= 1'b0;
         pc_q         <= PC_RESET;
         bus.inst_out <= 16'h0000;
         bus.reg_data <= 16'h0000;
         bus.reg_en   <= 2'b00;
         bus.reg_add  <= 3'd0;
         bus.mem_data <= 16'h0000;
         bus.mem_en   <= 1'b0;
         bus.mem_add  <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            rf[i] <= 16'h0000;
            dm[i] <= 16'h0000;
         end
      end else begin
         ir   <= bus.inst_in;
         // A taken jump turns the word fetched alongside it into a bubble.
         v_d  <= !(is_jmp && JMP_SQUASH);
         pc_q <= is_jmp ? imm8 : pc_q + 8'd1;

         bus.inst_out <= v_d ? ir : 16'h0000;
         bus.reg_data <= 16'h0000;
         bus.reg_en   <= 2'b00;
         bus.reg_add  <= 3'd0;
         bus.mem_data <= 16'h0000;
         bus.mem_en   <= 1'b0;
         bus.mem_add  <= 3'd0;

         if (v_d) begin
            case (op)
               4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                  rf[rd]       <= alu;
                  bus.reg_en   <= 2'b01;
                  bus.reg_add  <= rd;
                  bus.reg_data <= alu;
               end
               4'd7: begin
                  rf[rd]       <= dm[addr];
                  bus.reg_en   <= 2'b10;
                  bus.reg_add  <= rd;
                  bus.reg_data <= dm[addr];
               end
               4'd8: begin
                  dm[addr]     <= opa;
                  bus.mem_en   <= 1'b1;
                  bus.mem_add  <= addr;
                  bus.mem_data <= opa;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
